// File: rtl/sram_stream_reader.sv
// Burst read initiator for a single-port SRAM, presenting words as a valid/ready stream.
// Optional SRAM_RD_STALL_CNT_EN adds a saturating stall_cnt output.
module sram_stream_reader #(
    parameter int WL_ADDR = 8,
    parameter int WL_DATA = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WL_ADDR-1:0] base_addr,
    input  logic [WL_ADDR:0]   len,
    output logic               busy,
    output logic               done,
    output logic [WL_ADDR-1:0] sram_addr,
    output logic [WL_DATA-1:0] sram_wdata,
    output logic               sram_ena,
    input  logic [WL_DATA-1:0] sram_rdata,
    output logic               m_valid,
    output logic [WL_DATA-1:0] m_data,
    output logic               m_last,
    input  logic               m_ready
`ifdef SRAM_RD_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_t;

    localparam logic [WL_ADDR:0]   CNT_ONE  = 1;
    localparam logic [WL_ADDR-1:0] ADDR_ONE = 1;

    state_t             state_q, state_d;
    logic [WL_ADDR:0]   len_q, len_d;
    logic [WL_ADDR:0]   issue_cnt_q, issue_cnt_d;
    logic [WL_ADDR:0]   beat_cnt_q, beat_cnt_d;
    logic               pending_q, pending_d;
    logic [WL_ADDR-1:0] sram_addr_q, sram_addr_d;
    logic [WL_DATA-1:0] buf_q [2];
    logic [WL_DATA-1:0] buf_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SRAM_RD_STALL_CNT_EN
    logic [15:0]        stall_cnt_q, stall_cnt_d;
`endif

    logic               pop;
    logic               issue;
    logic               last_issue;
    logic               last_beat;
    logic [WL_ADDR:0]   len_m1;
    logic [2:0]         occ;
    logic [2:0]         room_lim;

    assign len_m1     = len_q - CNT_ONE;
    assign pop        = (count_q != 2'd0) && m_ready;
    assign last_issue = (issue_cnt_q == len_m1);
    assign last_beat  = (beat_cnt_q == len_m1);

    // Occupancy after this cycle's pop plus the read in flight must leave a free slot.
    assign occ      = {1'b0, count_q} + {2'b00, pending_q};
    assign room_lim = 3'd2 + {2'b00, pop};
    assign issue    = (state_q == ST_RUN) && (issue_cnt_q != len_q) && (occ < room_lim);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        sram_addr_d = sram_addr_q;
        buf_d[0]    = buf_q[0];
        buf_d[1]    = buf_q[1];
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pending_d   = issue;

        if (pending_q) begin
            buf_d[wr_ptr_q] = sram_rdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            beat_cnt_d = beat_cnt_q + CNT_ONE;
        end
        case ({pending_q, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = len;
                    issue_cnt_d = '0;
                    beat_cnt_d  = '0;
                    if (len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d     = ST_RUN;
                        sram_addr_d = base_addr;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end else begin
                        sram_addr_d = sram_addr_q + ADDR_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && last_beat) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

`ifdef SRAM_RD_STALL_CNT_EN
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_cnt_d = '0;
        end else if ((count_q != 2'd0) && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            pending_q   <= 1'b0;
            sram_addr_q <= '0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SRAM_RD_STALL_CNT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            pending_q   <= pending_d;
            sram_addr_q <= sram_addr_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SRAM_RD_STALL_CNT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = '0;
    assign sram_ena   = 1'b0;
    assign m_valid    = (count_q != 2'd0);
    assign m_data     = buf_q[rd_ptr_q];
    assign m_last     = m_valid && last_beat;
`ifdef SRAM_RD_STALL_CNT_EN
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule
